// File: rtl/mag_phase_serializer_pkg.sv
// Shared definitions for the magnitude/phase frame serializer.
// Default widths, the controller state type and the packed-slice index helper.
package mag_phase_serializer_pkg;

  localparam int N_CH_DEF    = 4;
  localparam int W_MAG_DEF   = 21;
  localparam int W_PHASE_DEF = 22;
  localparam int GAP_W       = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Bit offset of channel k inside a frame packed with w bits per channel.
  function automatic int slice_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/mag_phase_serializer_skid.sv
// One-entry frame holding register with a valid flag.
// A load overrides a take in the same cycle, so a frame can be handed over and refilled at once.
module frame_skid_buffer
  import mag_phase_serializer_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         take,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out,
  output logic         full
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  // Next contents of the holding register.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = data_in;
      valid_d = 1'b1;
    end else if (take) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Holding register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_out = data_q;
  assign full     = valid_q;

endmodule

// File: rtl/mag_phase_serializer.sv
// Serializes parallel mag/phase frames into one word per GAP+1 cycles, channel 0 first.
// One further frame may wait in the skid buffer; anything beyond that is dropped and flagged.
module mag_phase_serializer
  import mag_phase_serializer_pkg::*;
#(
  parameter int N_CH    = N_CH_DEF,
  parameter int W_MAG   = W_MAG_DEF,
  parameter int W_PHASE = W_PHASE_DEF,
  parameter int GAP     = 0
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [N_CH*W_MAG-1:0]     mags_in,
  input  logic [N_CH*W_PHASE-1:0]   phases_in,
  input  logic                      strobe_in,
  input  logic                      clr_overrun,
  output logic [W_MAG-1:0]          mag_out,
  output logic [W_PHASE-1:0]        phase_out,
  output logic [$clog2(N_CH)-1:0]   chan_out,
  output logic                      frame_start,
  output logic                      strobe_out,
  output logic                      busy,
  output logic                      overrun
);

  localparam int                CW      = $clog2(N_CH);
  localparam int                MW      = N_CH * W_MAG;
  localparam int                PW      = N_CH * W_PHASE;
  localparam logic [CW-1:0]     LAST_CH = CW'(N_CH - 1);
  localparam logic [GAP_W-1:0]  GAP_V   = GAP_W'(GAP);

  state_e               state_q, state_d;
  logic [MW-1:0]        a_mags_q, a_mags_d;
  logic [PW-1:0]        a_phases_q, a_phases_d;
  logic [CW-1:0]        chan_q, chan_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [W_MAG-1:0]     mag_out_q, mag_out_d;
  logic [W_PHASE-1:0]   phase_out_q, phase_out_d;
  logic [CW-1:0]        chan_out_q, chan_out_d;
  logic                 strobe_q, strobe_d;
  logic                 frame_start_q, frame_start_d;
  logic                 overrun_q, overrun_d;

  logic                 p_load_s, p_take_s, p_full_s, last_word_s;
  logic [MW+PW-1:0]     p_data_s;

  frame_skid_buffer #(
    .W (MW + PW)
  ) u_skid (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .load     (p_load_s),
    .take     (p_take_s),
    .data_in  ({phases_in, mags_in}),
    .data_out (p_data_s),
    .full     (p_full_s)
  );

  // Sequencing of the active frame, pending-frame handover and overrun flag.
  always_comb begin
    state_d       = state_q;
    a_mags_d      = a_mags_q;
    a_phases_d    = a_phases_q;
    chan_d        = chan_q;
    gap_d         = gap_q;
    mag_out_d     = mag_out_q;
    phase_out_d   = phase_out_q;
    chan_out_d    = chan_out_q;
    strobe_d      = 1'b0;
    frame_start_d = 1'b0;
    overrun_d     = overrun_q & ~clr_overrun;
    p_load_s      = 1'b0;
    p_take_s      = 1'b0;
    last_word_s   = 1'b0;

    case (state_q)
      IDLE: begin
        if (strobe_in) begin
          a_mags_d   = mags_in;
          a_phases_d = phases_in;
          chan_d     = '0;
          gap_d      = '0;
          state_d    = SEND;
        end else begin
          state_d = IDLE;
        end
      end

      SEND: begin
        if (gap_q == '0) begin
          mag_out_d     = a_mags_q[slice_lsb(int'(chan_q), W_MAG) +: W_MAG];
          phase_out_d   = a_phases_q[slice_lsb(int'(chan_q), W_PHASE) +: W_PHASE];
          chan_out_d    = chan_q;
          strobe_d      = 1'b1;
          frame_start_d = (chan_q == '0);
          gap_d         = GAP_V;
          if (chan_q == LAST_CH) begin
            last_word_s = 1'b1;
            chan_d      = '0;
            if (p_full_s) begin
              a_mags_d   = p_data_s[MW-1:0];
              a_phases_d = p_data_s[MW+PW-1:MW];
              p_take_s   = 1'b1;
            end else if (strobe_in) begin
              // A frame arriving on the last word bypasses the buffer.
              a_mags_d   = mags_in;
              a_phases_d = phases_in;
            end else begin
              state_d = IDLE;
            end
          end else begin
            chan_d = chan_q + CW'(1);
          end
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end

        if (strobe_in && !(last_word_s && !p_full_s)) begin
          if (!p_full_s || p_take_s) begin
            p_load_s = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          p_load_s = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= IDLE;
      a_mags_q      <= '0;
      a_phases_q    <= '0;
      chan_q        <= '0;
      gap_q         <= '0;
      mag_out_q     <= '0;
      phase_out_q   <= '0;
      chan_out_q    <= '0;
      strobe_q      <= 1'b0;
      frame_start_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_mags_q      <= a_mags_d;
      a_phases_q    <= a_phases_d;
      chan_q        <= chan_d;
      gap_q         <= gap_d;
      mag_out_q     <= mag_out_d;
      phase_out_q   <= phase_out_d;
      chan_out_q    <= chan_out_d;
      strobe_q      <= strobe_d;
      frame_start_q <= frame_start_d;
      overrun_q     <= overrun_d;
    end
  end

  assign mag_out     = mag_out_q;
  assign phase_out   = phase_out_q;
  assign chan_out    = chan_out_q;
  assign strobe_out  = strobe_q;
  assign frame_start = frame_start_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q == SEND) | p_full_s;

endmodule

// File: tb/tb_mag_phase_serializer.sv
// Bench for mag_phase_serializer: three instances (GAP 0,1,2) share stimulus and are
// checked against a frame-schedule model that predicts the edge of every output word.
module tb_mag_phase_serializer;

  localparam int N  = 4;
  localparam int WM = 21;
  localparam int WP = 22;
  localparam int CW = 2;
  localparam int PW = WM + WP + CW + 1;

  logic            sys_clk = 1'b0;
  logic            sys_rst_n = 1'b0;
  logic [N*WM-1:0] mags_in = '0;
  logic [N*WP-1:0] phases_in = '0;
  logic            strobe_in = 1'b0;
  logic            clr_overrun = 1'b0;

  logic [WM-1:0]   mag_o   [3];
  logic [WP-1:0]   phase_o [3];
  logic [CW-1:0]   chan_o  [3];
  logic            fs_o    [3];
  logic            stb_o   [3];
  logic            busy_o  [3];
  logic            ov_o    [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mag_phase_serializer #(
      .N_CH(N), .W_MAG(WM), .W_PHASE(WP), .GAP(g)
    ) u_dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .mags_in     (mags_in),
      .phases_in   (phases_in),
      .strobe_in   (strobe_in),
      .clr_overrun (clr_overrun),
      .mag_out     (mag_o[g]),
      .phase_out   (phase_o[g]),
      .chan_out    (chan_o[g]),
      .frame_start (fs_o[g]),
      .strobe_out  (stb_o[g]),
      .busy        (busy_o[g]),
      .overrun     (ov_o[g])
    );
  end

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: every accepted frame is a handover edge plus the edge of its last word;
  // expected output words are stored by the edge after which they must be visible.
  logic [PW-1:0] exp_word [int];
  int            fr_ld [$];
  int            fr_last [$];
  bit            mdl_ov;
  int            stb_offs [$];
  int            clr_offs [$];

  int            ob_e;
  logic [PW:0]   ob_pkt;
  logic [1:0]    ob_bo;

  task automatic model_reset();
    exp_word.delete();
    fr_ld.delete();
    fr_last.delete();
    mdl_ov = 1'b0;
  endtask

  task automatic model_strobe(input int g, input int s, input logic [N*WM-1:0] m,
                              input logic [N*WP-1:0] p, output bit drop);
    int mx;
    int ld;
    int st;
    mx = -1;
    drop = 1'b0;
    foreach (fr_ld[j]) begin
      if (fr_ld[j] > s) drop = 1'b1;
      if (fr_last[j] > mx) mx = fr_last[j];
    end
    if (drop) begin
      mdl_ov = 1'b1;
    end else begin
      if (mx >= s) begin
        ld = mx;
        st = mx + g + 1;
      end else begin
        ld = s;
        st = s + 1;
      end
      fr_ld.push_back(ld);
      fr_last.push_back(st + (N - 1) * (g + 1));
      for (int k = 0; k < N; k++)
        exp_word[st + k * (g + 1)] = {m[k*WM +: WM], p[k*WP +: WP], CW'(k), k == 0};
    end
  endtask

  function automatic logic [PW:0] mdl_pkt(input int e);
    if (exp_word.exists(e)) return {1'b1, exp_word[e]};
    return '0;
  endfunction

  function automatic bit mdl_busy(input int e);
    foreach (fr_ld[j])
      if (fr_ld[j] <= e && e < fr_last[j]) return 1'b1;
    return 1'b0;
  endfunction

  // Drives one cycle of stimulus (index i of the current scenario) and samples instance g.
  task automatic step(input int g, input int i, input bit fixed);
    logic [N*WM-1:0] m;
    logic [N*WP-1:0] p;
    bit drop;
    bit s;
    bit c;
    s = 1'b0;
    c = 1'b0;
    drop = 1'b0;
    foreach (stb_offs[j]) if (stb_offs[j] == i) s = 1'b1;
    foreach (clr_offs[j]) if (clr_offs[j] == i) c = 1'b1;
    @(negedge sys_clk);
    for (int k = 0; k < N; k++) begin
      m[k*WM +: WM] = fixed ? WM'(k + 1) : WM'($urandom);
      p[k*WP +: WP] = fixed ? WP'(10 * (k + 1)) : WP'($urandom);
    end
    mags_in = m;
    phases_in = p;
    strobe_in = s;
    clr_overrun = c;
    if (s) model_strobe(g, cyc + 1, m, p, drop);
    if (c && !drop) mdl_ov = 1'b0;
    @(posedge sys_clk);
    #1;
    ob_e = cyc;
    ob_pkt = {stb_o[g], stb_o[g] ? {mag_o[g], phase_o[g], chan_o[g], fs_o[g]} : (PW)'(0)};
    ob_bo = {busy_o[g], ov_o[g]};
  endtask

  task automatic apply_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    strobe_in = 1'b0;
    clr_overrun = 1'b0;
    model_reset();
    stb_offs.delete();
    clr_offs.delete();
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int g = 0; g < 3; g++) begin
      tests_run++;
      if ({stb_o[g], fs_o[g], busy_o[g], ov_o[g], mag_o[g], phase_o[g], chan_o[g]} !== '0) begin
        tests_failed++;
        $display("FAIL reset inst%0d: got stb=%b fs=%b busy=%b ov=%b mag=%h ph=%h ch=%0d want all 0",
                 g, stb_o[g], fs_o[g], busy_o[g], ov_o[g], mag_o[g], phase_o[g], chan_o[g]);
      end
    end
  endtask

  task automatic test_basic();
    apply_reset();
    stb_offs = '{0};
    for (int i = 0; i < 8; i++) begin
      step(0, i, 1'b1);
      tests_run++;
      if (ob_pkt !== mdl_pkt(ob_e)) begin
        tests_failed++;
        $display("FAIL basic word @%0d: got %h want %h", ob_e, ob_pkt, mdl_pkt(ob_e));
      end
      tests_run++;
      if (ob_bo !== {mdl_busy(ob_e), mdl_ov}) begin
        tests_failed++;
        $display("FAIL basic busy/ov @%0d: got %b want %b", ob_e, ob_bo, {mdl_busy(ob_e), mdl_ov});
      end
    end
  endtask

  task automatic test_gap();
    apply_reset();
    stb_offs = '{1};
    for (int i = 0; i < 16; i++) begin
      step(2, i, 1'b0);
      tests_run++;
      if (ob_pkt !== mdl_pkt(ob_e)) begin
        tests_failed++;
        $display("FAIL gap2 word @%0d: got %h want %h", ob_e, ob_pkt, mdl_pkt(ob_e));
      end
      tests_run++;
      if (ob_bo !== {mdl_busy(ob_e), mdl_ov}) begin
        tests_failed++;
        $display("FAIL gap2 busy/ov @%0d: got %b want %b", ob_e, ob_bo, {mdl_busy(ob_e), mdl_ov});
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    stb_offs = '{0, 2};
    for (int i = 0; i < 12; i++) begin
      step(0, i, 1'b0);
      tests_run++;
      if (ob_pkt !== mdl_pkt(ob_e)) begin
        tests_failed++;
        $display("FAIL b2b word @%0d: got %h want %h", ob_e, ob_pkt, mdl_pkt(ob_e));
      end
      tests_run++;
      if (ob_bo !== {mdl_busy(ob_e), mdl_ov}) begin
        tests_failed++;
        $display("FAIL b2b busy/ov @%0d: got %b want %b", ob_e, ob_bo, {mdl_busy(ob_e), mdl_ov});
      end
    end
  endtask

  task automatic test_overrun();
    apply_reset();
    // Three frames on consecutive cycles, then a lone clear, then clear coinciding with a drop.
    for (int ph = 0; ph < 3; ph++) begin
      stb_offs.delete();
      clr_offs.delete();
      if (ph != 1) stb_offs = '{0, 1, 2};
      if (ph == 1) clr_offs = '{1};
      if (ph == 2) clr_offs = '{2};
      for (int i = 0; i < 12; i++) begin
        step(0, i, 1'b0);
        tests_run++;
        if (ob_pkt !== mdl_pkt(ob_e)) begin
          tests_failed++;
          $display("FAIL overrun word @%0d: got %h want %h", ob_e, ob_pkt, mdl_pkt(ob_e));
        end
        tests_run++;
        if (ob_bo !== {mdl_busy(ob_e), mdl_ov}) begin
          tests_failed++;
          $display("FAIL overrun busy/ov @%0d: got %b want %b", ob_e, ob_bo, {mdl_busy(ob_e), mdl_ov});
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    stb_offs = '{0};
    for (int i = 0; i < 3; i++) begin
      step(0, i, 1'b0);
      tests_run++;
      if (ob_pkt !== mdl_pkt(ob_e)) begin
        tests_failed++;
        $display("FAIL midrst pre word @%0d: got %h want %h", ob_e, ob_pkt, mdl_pkt(ob_e));
      end
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    tests_run++;
    if ({stb_o[0], fs_o[0], busy_o[0], ov_o[0], mag_o[0], phase_o[0], chan_o[0]} !== '0) begin
      tests_failed++;
      $display("FAIL midrst async: got stb=%b busy=%b mag=%h ph=%h ch=%0d want all 0",
               stb_o[0], busy_o[0], mag_o[0], phase_o[0], chan_o[0]);
    end
    model_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    stb_offs = '{4};
    for (int i = 0; i < 10; i++) begin
      step(0, i, 1'b0);
      tests_run++;
      if (ob_pkt !== mdl_pkt(ob_e)) begin
        tests_failed++;
        $display("FAIL midrst post word @%0d: got %h want %h", ob_e, ob_pkt, mdl_pkt(ob_e));
      end
      tests_run++;
      if (ob_bo !== {mdl_busy(ob_e), mdl_ov}) begin
        tests_failed++;
        $display("FAIL midrst busy/ov @%0d: got %b want %b", ob_e, ob_bo, {mdl_busy(ob_e), mdl_ov});
      end
    end
  endtask

  task automatic test_boundary();
    apply_reset();
    stb_offs = '{0, 7};
    for (int i = 0; i < 18; i++) begin
      step(1, i, 1'b0);
      tests_run++;
      if (ob_pkt !== mdl_pkt(ob_e)) begin
        tests_failed++;
        $display("FAIL boundary word @%0d: got %h want %h", ob_e, ob_pkt, mdl_pkt(ob_e));
      end
      tests_run++;
      if (ob_bo !== {mdl_busy(ob_e), mdl_ov}) begin
        tests_failed++;
        $display("FAIL boundary busy/ov @%0d: got %b want %b", ob_e, ob_bo, {mdl_busy(ob_e), mdl_ov});
      end
    end
  endtask

  task automatic test_random();
    for (int g = 0; g < 3; g++) begin
      apply_reset();
      for (int i = 0; i < 50; i++) begin
        if ($urandom_range(0, 3) == 0) stb_offs.push_back(i);
        if ($urandom_range(0, 9) == 0) clr_offs.push_back(i);
      end
      for (int i = 0; i < 80; i++) begin
        step(g, i, 1'b0);
        tests_run++;
        if (ob_pkt !== mdl_pkt(ob_e)) begin
          tests_failed++;
          $display("FAIL random g%0d word @%0d: got %h want %h", g, ob_e, ob_pkt, mdl_pkt(ob_e));
        end
        tests_run++;
        if (ob_bo !== {mdl_busy(ob_e), mdl_ov}) begin
          tests_failed++;
          $display("FAIL random g%0d busy/ov @%0d: got %b want %b", g, ob_e, ob_bo,
                   {mdl_busy(ob_e), mdl_ov});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_back_to_back();
    test_overrun();
    test_reset_mid_frame();
    test_boundary();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
